stopwatch_countup: RTL and testbench

- Up-counting seconds stopwatch with start/stop and lap buttons.
- Drives two active-low 7-segment digits (tens, ones) and a 3-bit status light.
- Companion to the board's countdown timer: counts up from 0 instead of down, and shares the same display encoding and light pins.
- Sits at board top level, fed by raw push-buttons and the 50 MHz board clock.

---
 rtl/stopwatch_countup.sv | 157 +++++++++++++++
 tb/tb_stopwatch_countup.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_countup.sv
// Up-counting seconds stopwatch with start/stop and lap buttons.
// Drives two active-low 7-segment digits (gfedcba) and a 3-bit status light.
module stopwatch_countup #(
    parameter int TICK_CYCLES = 50000000,
    parameter int MAX_COUNT   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    output logic [6:0] out10,
    output logic [6:0] out1,
    output logic [2:0] light
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [6:0]    SEC_MAX    = 7'(MAX_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_LAP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sec_q, sec_d;
    logic [6:0]    lap_q, lap_d;
    // Bit 0 tracks start_stop, bit 1 tracks lap.
    logic [1:0]    btn_s1_q, btn_s1_d;
    logic [1:0]    btn_s2_q, btn_s2_d;
    logic [1:0]    btn_hist_q, btn_hist_d;

    logic [1:0] press;
    logic       start_p, lap_p;
    logic [6:0] disp, tens, ones;

    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    seg7 = 7'b1000000;
            7'd1:    seg7 = 7'b1111001;
            7'd2:    seg7 = 7'b0100100;
            7'd3:    seg7 = 7'b0110000;
            7'd4:    seg7 = 7'b0011001;
            7'd5:    seg7 = 7'b0010010;
            7'd6:    seg7 = 7'b0000010;
            7'd7:    seg7 = 7'b1111000;
            7'd8:    seg7 = 7'b0000000;
            7'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            lap_q      <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_hist_q <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            lap_q      <= lap_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_hist_q <= btn_hist_d;
        end
    end

    always_comb begin
        btn_s1_d   = {lap, start_stop};
        btn_s2_d   = btn_s1_q;
        btn_hist_d = btn_s2_q;
        press      = btn_s2_q & ~btn_hist_q;
        start_p    = press[0];
        lap_p      = press[1];

        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        lap_d   = lap_q;

        // The tick that reaches MAX_COUNT stays in RUN/LAP; the next terminal tick enters DONE.
        if (state_q == S_RUN || state_q == S_LAP) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (sec_q == SEC_MAX) begin
                    state_d = S_DONE;
                end else begin
                    sec_d = sec_q + 7'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    sec_d   = '0;
                end
            end
            S_RUN: begin
                if (start_p) begin
                    state_d = S_HOLD;
                end else if (lap_p) begin
                    state_d = S_LAP;
                    lap_d   = sec_q;
                end
            end
            S_HOLD: begin
                if (start_p) begin
                    state_d = S_RUN;
                end else if (lap_p) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    sec_d   = '0;
                end
            end
            S_LAP: begin
                if (start_p) begin
                    state_d = S_HOLD;
                end else if (lap_p) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (lap_p) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    sec_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp  = (state_q == S_LAP) ? lap_q : sec_q;
        tens  = disp / 7'd10;
        ones  = disp % 7'd10;
        out10 = seg7(tens);
        out1  = seg7(ones);
        case (state_q)
            S_IDLE:  light = 3'b001;
            S_RUN:   light = 3'b100;
            S_HOLD:  light = 3'b010;
            S_LAP:   light = 3'b110;
            S_DONE:  light = 3'b111;
            default: light = 3'b001;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_countup.sv
// Directed bench for stopwatch_countup with TICK_CYCLES=4, MAX_COUNT=12.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_countup;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       lap;
    logic [6:0] out10;
    logic [6:0] out1;
    logic [2:0] light;

    int checks;
    int errors;

    stopwatch_countup #(.TICK_CYCLES(4), .MAX_COUNT(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .out10      (out10),
        .out1       (out1),
        .light      (light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       seg = 7'b1000000;
            1:       seg = 7'b1111001;
            2:       seg = 7'b0100100;
            3:       seg = 7'b0110000;
            4:       seg = 7'b0011001;
            5:       seg = 7'b0010010;
            6:       seg = 7'b0000010;
            7:       seg = 7'b1111000;
            8:       seg = 7'b0000000;
            9:       seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int val, input logic [2:0] lt);
        chk({tag, "_tens"}, out10, seg(val / 10));
        chk({tag, "_ones"}, out1, seg(val % 10));
        chk({tag, "_light"}, {4'b0000, light}, {4'b0000, lt});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle press; returns after the edge at which the state reacts.
    task automatic press(input logic s, input logic l);
        start_stop = s;
        lap        = l;
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        cyc(3);
        chk_disp("reset", 0, 3'b001);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(10);
            chk_disp("idle", 0, 3'b001);
        end

        // Start, tick spacing of 4 cycles
        press(1'b1, 1'b0);
        chk_disp("run0", 0, 3'b100);
        cyc(3);
        chk_disp("run_pre1", 0, 3'b100);
        cyc(1);
        chk_disp("run1", 1, 3'b100);
        cyc(8);
        chk_disp("run3", 3, 3'b100);

        // Hold at 3, resume with the partially used prescaler
        press(1'b1, 1'b0);
        chk_disp("hold", 3, 3'b010);
        cyc(40);
        chk_disp("hold40", 3, 3'b010);
        press(1'b1, 1'b0);
        chk_disp("resume", 3, 3'b100);
        cyc(1);
        chk_disp("resume_tick", 4, 3'b100);

        // Lap at 4 while counting continues underneath
        press(1'b0, 1'b1);
        chk_disp("lap", 4, 3'b110);
        cyc(9);
        chk_disp("lap_frozen", 4, 3'b110);
        press(1'b0, 1'b1);
        chk_disp("lap_exit", 7, 3'b100);
        cyc(1);
        chk_disp("run8", 8, 3'b100);

        // Terminal value and DONE
        cyc(16);
        chk_disp("run12", 12, 3'b100);
        cyc(3);
        chk_disp("pre_done", 12, 3'b100);
        cyc(1);
        chk_disp("done", 12, 3'b111);
        press(1'b1, 1'b0);
        chk_disp("done_start", 12, 3'b111);
        cyc(10);
        chk_disp("done_stay", 12, 3'b111);
        press(1'b0, 1'b1);
        chk_disp("done_lap", 0, 3'b001);

        // Reset mid-run with start_stop held through release
        press(1'b1, 1'b0);
        chk_disp("rerun0", 0, 3'b100);
        cyc(20);
        chk_disp("rerun5", 5, 3'b100);
        cyc(16);
        chk_disp("rerun9", 9, 3'b100);
        start_stop = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk_disp("async_rst", 0, 3'b001);
        cyc(3);
        chk_disp("rst_held", 0, 3'b001);
        reset = 1'b1;
        cyc(2);
        chk_disp("rel_wait", 0, 3'b001);
        cyc(1);
        chk_disp("rel_run", 0, 3'b100);
        cyc(10);
        chk_disp("held_norep", 2, 3'b100);
        start_stop = 1'b0;
        cyc(5);
        chk_disp("released", 3, 3'b100);

        // Simultaneous start and lap in RUN
        press(1'b1, 1'b1);
        chk_disp("both", 4, 3'b010);
        cyc(8);
        chk_disp("both_hold", 4, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
